// File: rtl/glitcher_pkg.sv
// glitcher_pkg: shared opcode/response byte constants and decoder state type
package glitcher_pkg;
  localparam logic [7:0] OP_DELAY  = 8'h64;
  localparam logic [7:0] OP_WIDTH  = 8'h77;
  localparam logic [7:0] OP_ARM    = 8'h61;
  localparam logic [7:0] OP_GLITCH = 8'h67;
  localparam logic [7:0] OP_STATUS = 8'h73;
  localparam logic [7:0] RSP_OK    = 8'h6B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;
  typedef enum logic [1:0] {IDLE, ARG_HI, ARG_LO, RESP} state_e;
endpackage

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: decodes UART command bytes into glitch registers, pulses and one response byte
//   rx_data_i/rx_valid_i: incoming bytes; status_i: status byte for 's'
//   delay_o/width_o: 16-bit registers; arm_o/trigger_o: one-cycle pulses
//   tx_data_o/tx_valid_o/tx_ready_i: response handshake
module uart_cmd_decoder
  import glitcher_pkg::*;
#(
  parameter int TIMEOUT_CLKS      = 500000,
  parameter int TIMEOUT_CNT_WIDTH = $clog2(TIMEOUT_CLKS + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  status_i,
  output logic [15:0] delay_o,
  output logic [15:0] width_o,
  output logic        arm_o,
  output logic        trigger_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);
  state_e                       state_q, state_d;
  logic                         is_delay_q, is_delay_d;
  logic [7:0]                   msb_q, msb_d, tx_data_q, tx_data_d;
  logic [15:0]                  delay_q, delay_d, width_q, width_d;
  logic                         arm_q, arm_d, trig_q, trig_d;
  logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                         in_arg, expired;
  assign in_arg  = state_q == ARG_HI || state_q == ARG_LO;
  // a byte in the expiry cycle wins because rx_valid_i is tested first below
  assign expired = cnt_q == TIMEOUT_CNT_WIDTH'(TIMEOUT_CLKS);
  always_comb begin
    state_d    = state_q;
    is_delay_d = is_delay_q;
    msb_d      = msb_q;
    tx_data_d  = tx_data_q;
    delay_d    = delay_q;
    width_d    = width_q;
    arm_d      = 1'b0;
    trig_d     = 1'b0;
    cnt_d      = in_arg && !rx_valid_i ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (rx_valid_i) begin
        is_delay_d = rx_data_i == OP_DELAY;
        if (rx_data_i == OP_DELAY || rx_data_i == OP_WIDTH) state_d = ARG_HI;
        else begin
          state_d   = RESP;
          arm_d     = rx_data_i == OP_ARM;
          trig_d    = rx_data_i == OP_GLITCH;
          tx_data_d = rx_data_i == OP_STATUS ? status_i :
                      (rx_data_i == OP_ARM || rx_data_i == OP_GLITCH) ? RSP_OK : RSP_ERR;
        end
      end
      ARG_HI: if (rx_valid_i) begin
        msb_d   = rx_data_i;
        state_d = ARG_LO;
      end else if (expired) state_d = IDLE;
      ARG_LO: if (rx_valid_i) begin
        delay_d   = is_delay_q ? {msb_q, rx_data_i} : delay_q;
        width_d   = is_delay_q ? width_q : {msb_q, rx_data_i};
        tx_data_d = RSP_OK;
        state_d   = RESP;
      end else if (expired) state_d = IDLE;
      default: state_d = tx_ready_i ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_delay_q <= 1'b0;
      msb_q      <= '0;
      tx_data_q  <= '0;
      delay_q    <= '0;
      width_q    <= '0;
      arm_q      <= 1'b0;
      trig_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_delay_q <= is_delay_d;
      msb_q      <= msb_d;
      tx_data_q  <= tx_data_d;
      delay_q    <= delay_d;
      width_q    <= width_d;
      arm_q      <= arm_d;
      trig_q     <= trig_d;
      cnt_q      <= cnt_d;
    end
  end
  assign delay_o    = delay_q;
  assign width_o    = width_q;
  assign arm_o      = arm_q;
  assign trigger_o  = trig_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = state_q == RESP;
endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 500000, meaning clocks allowed between argument bytes before the partial command is discarded.
REQ-002 SHALL have parameter TIMEOUT_CNT_WIDTH, default $clog2(TIMEOUT_CLKS+1), meaning timeout counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data_i  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_valid_i  input  1  one-cycle strobe, rx_data_i valid.
REQ-007 SHALL have port status_i  input  8  status byte returned by the status command.
REQ-008 SHALL have port delay_o  output  16  glitch delay register.
REQ-009 SHALL have port width_o  output  16  glitch pulse-width register.
REQ-010 SHALL have port arm_o  output  1  one-cycle arm pulse.
REQ-011 SHALL have port trigger_o  output  1  one-cycle immediate-glitch pulse.
REQ-012 SHALL have port tx_data_o  output  8  response byte to the UART transmitter.
REQ-013 SHALL have port tx_valid_o  output  1  response valid; held until accepted.
REQ-014 SHALL have port tx_ready_i  input  1  transmitter accepts tx_data_o when tx_valid_o and tx_ready_i are both high.

Function
REQ-015 SHALL implement states IDLE, ARG_HI, ARG_LO, RESP.
REQ-016 SHALL, in IDLE on rx_valid_i, decode the opcode: 0x64 'd' and 0x77 'w' go to ARG_HI; 0x61 'a', 0x67 'g', 0x73 's' and any unknown byte go to RESP.
REQ-017 SHALL, on a byte in ARG_HI, latch it as the argument MSB and go to ARG_LO.
REQ-018 SHALL, on a byte in ARG_LO, write {MSB, byte} to delay_o ('d') or width_o ('w') and go to RESP with 0x6B 'k'.
REQ-019 SHALL go to RESP with response 0x6B for 'a' and pulse arm_o.
REQ-020 SHALL go to RESP with response 0x6B for 'g' and pulse trigger_o.
REQ-021 SHALL go to RESP with response status_i for 's', sampled in the cycle the opcode is accepted.
REQ-022 SHALL go to RESP with response 0x3F '?' for any other opcode.
REQ-023 SHALL assert tx_valid_o, arm_o, trigger_o and the register update in the cycle after the final command byte's rx_valid_i; latency is exactly 1 clock.
REQ-024 SHALL hold tx_valid_o and tx_data_o stable in RESP until tx_ready_i, then drop tx_valid_o the next cycle and return to IDLE.
REQ-025 SHALL silently drop bytes arriving in RESP; state and registers are unchanged.
REQ-026 SHALL run the timeout counter only in ARG_HI/ARG_LO, clearing it on every accepted byte and on entry to those states.
REQ-027 SHALL return to IDLE when the counter reaches TIMEOUT_CLKS, with no response, no register write and no pulse.
REQ-028 SHALL give priority to a byte arriving in the same cycle the timeout is reached; the byte is accepted and the timeout ignored.
REQ-029 SHALL accept each arm_o/trigger_o pulse as exactly one cycle per command; back-to-back commands produce separate pulses.

Reset
REQ-030 SHALL, on rst, set state IDLE, delay_o 0, width_o 0, arm_o 0, trigger_o 0, tx_valid_o 0, tx_data_o 0, and the counter and argument latch to 0.
REQ-031 SHALL, when rst is asserted mid-command or mid-response, abandon the command or response with no pending output, so the first byte after reset is decoded as an opcode.

Structure
REQ-032 SHALL place opcode and response-byte constants (0x64, 0x77, 0x61, 0x67, 0x73, 0x6B, 0x3F) in the shared glitcher_pkg package, used by the decoder and by benches.
REQ-033 SHALL be a single module with no sub-modules; the timeout counter and FSM are inline.

Verification
REQ-034 SHALL verify: bytes 0x64,0x12,0x34 with tx_ready_i=1 -> delay_o=0x1234 and one tx byte 0x6B, one cycle after the 0x34 strobe.
REQ-035 SHALL verify: 0x61 then 0x67 -> one-cycle arm_o then one-cycle trigger_o, each followed by a 0x6B response.
REQ-036 SHALL verify: 0x77,0xAB then idle for TIMEOUT_CLKS (set to 100) -> return to IDLE with width_o unchanged and no tx; the next 0x73 with status_i=0x5A -> response 0x5A.
REQ-037 SHALL verify: opcode 0x00 with tx_ready_i=0 for 20 cycles -> tx_valid_o=1 and tx_data_o=0x3F held stable throughout; a byte sent meanwhile is dropped.
REQ-038 SHALL verify: rst asserted after 0x64,0x01 -> all outputs 0; then 0x12 is answered with 0x3F.
REQ-039 SHALL verify: a byte strobe coincident with the timeout expiry in ARG_LO -> the register is written and 0x6B is returned.
